// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 key-schedule controller.
package aes_ctrl_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [3:0] round_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ROUND,
        REPLAY
    } ctrl_state_t;

endpackage

// File: rtl/aes_rk_cache.sv
// Round-key store for schedule replay; used only when AES_KEY_CACHE_EN is defined.
module aes_rk_cache
    import aes_ctrl_pkg::*;
#(
    parameter int DEPTH = AES_NR + 1,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  round_idx_t       wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  round_idx_t       rd_idx,
    output logic [KEY_W-1:0] rd_data,
    input  logic             set_valid,
    input  logic             clr_valid,
    output logic             valid
);

    logic [KEY_W-1:0] mem [DEPTH];

    // NOTE: the key store is not reset; valid gates its use, so only the flag needs a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (clr_valid) begin
            valid <= 1'b0;
        end else if (set_valid) begin
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: key load handshake, round keys 0..10 out with backpressure.
// Define AES_KEY_CACHE_EN to record each schedule and replay it in reverse order.
module aes_key_sched_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int KEY_W      = AES_KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] cipher_key,
    input  logic             abort,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [3:0]       rk_idx,
    output logic [KEY_W-1:0] rk_data,
    output logic             sched_done,
    output logic [KEY_W-1:0] ke_cipher_key,
    output logic             ke_cipher_new_en,
    output logic             ke_round_key_en,
    output logic [3:0]       ke_round_num,
    output logic             ke_en,
    input  logic [KEY_W-1:0] ke_round_key,
    input  logic             replay_req,
    output logic             cache_valid
);

    localparam round_idx_t LAST_IDX = round_idx_t'(NUM_ROUNDS);

    ctrl_state_t      state, state_next;
    round_idx_t       idx, idx_next;
    logic [KEY_W-1:0] key_reg;
    logic             transfer, key_load, last_fwd, last_rev, replay_start;

    assign transfer = rk_valid & rk_ready & ~abort;
    assign key_load = key_ready & key_valid;
    assign last_fwd = (state == ROUND) && transfer && (idx == LAST_IDX);

`ifdef AES_KEY_CACHE_EN
    logic [KEY_W-1:0] cache_rd_data;

    assign last_rev     = (state == REPLAY) && transfer && (idx == '0);
    assign replay_start = (state == IDLE) && replay_req && cache_valid && !key_valid && !abort;

    // Every forward key handed over is recorded at its own index.
    aes_rk_cache #(
        .DEPTH(NUM_ROUNDS + 1),
        .KEY_W(KEY_W)
    ) u_cache (
        .clk      (clk),
        .reset    (reset),
        .we       (transfer && (state == FIRST || state == ROUND)),
        .wr_idx   (rk_idx),
        .wr_data  (rk_data),
        .rd_idx   (idx),
        .rd_data  (cache_rd_data),
        .set_valid(last_fwd),
        .clr_valid(abort | key_load),
        .valid    (cache_valid)
    );
`else
    logic unused_replay;

    assign unused_replay = replay_req;
    assign last_rev      = 1'b0;
    assign replay_start  = 1'b0;
    assign cache_valid   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (key_load)          state_next = FIRST;
                else if (replay_start) state_next = REPLAY;
            end
            FIRST:   if (transfer) state_next = ROUND;
            ROUND:   if (last_fwd) state_next = IDLE;
            REPLAY:  if (last_rev) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_comb begin
        idx_next = idx;
        if (abort) begin
            idx_next = '0;
        end else begin
            case (state)
                IDLE:    idx_next = replay_start ? LAST_IDX : '0;
                FIRST:   if (transfer) idx_next = round_idx_t'(1);
                ROUND:   if (transfer) idx_next = last_fwd ? '0 : round_idx_t'(idx + 4'd1);
                REPLAY:  if (transfer && idx != '0) idx_next = round_idx_t'(idx - 4'd1);
                default: idx_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg    <= '0;
            idx        <= '0;
            sched_done <= 1'b0;
        end else begin
            if (key_load) key_reg <= cipher_key;
            idx        <= idx_next;
            sched_done <= last_fwd | last_rev;
        end
    end

    assign ke_cipher_key = key_reg;

    // Strobes use rk_ready & ~abort directly; the state already implies rk_valid.
    always_comb begin
        key_ready        = 1'b0;
        rk_valid         = 1'b0;
        rk_idx           = '0;
        rk_data          = '0;
        ke_cipher_new_en = 1'b0;
        ke_round_key_en  = 1'b0;
        ke_round_num     = '0;
        ke_en            = 1'b0;
        case (state)
            IDLE: key_ready = ~abort;
            FIRST: begin
                rk_valid         = 1'b1;
                rk_data          = key_reg;
                ke_en            = 1'b1;
                ke_cipher_new_en = rk_ready & ~abort;
            end
            ROUND: begin
                rk_valid        = 1'b1;
                rk_idx          = idx;
                rk_data         = ke_round_key;
                ke_en           = 1'b1;
                ke_round_num    = idx;
                ke_round_key_en = rk_ready & ~abort & (idx < LAST_IDX);
            end
`ifdef AES_KEY_CACHE_EN
            REPLAY: begin
                rk_valid = 1'b1;
                rk_idx   = idx;
                rk_data  = cache_rd_data;
                ke_en    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with a behavioural AES-128 expander and schedule model.
// Cache replay scenarios are compiled when AES_KEY_CACHE_EN is defined.
module tb_aes_key_sched_ctrl;

    localparam int KW = 128;
    localparam logic [KW-1:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [KW-1:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    logic          clk = 1'b0;
    logic          reset, key_valid, key_ready, abort, rk_valid, rk_ready, sched_done;
    logic [KW-1:0] cipher_key, rk_data, ke_cipher_key, ke_round_key;
    logic [3:0]    rk_idx, ke_round_num;
    logic          ke_cipher_new_en, ke_round_key_en, ke_en, replay_req, cache_valid;

    int checks = 0;
    int failures = 0;

    logic [7:0]    sbox_tab [256];
    logic [KW-1:0] ref_rk [11];
    logic [KW-1:0] exp_reg = '0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .key_valid       (key_valid),
        .key_ready       (key_ready),
        .cipher_key      (cipher_key),
        .abort           (abort),
        .rk_valid        (rk_valid),
        .rk_ready        (rk_ready),
        .rk_idx          (rk_idx),
        .rk_data         (rk_data),
        .sched_done      (sched_done),
        .ke_cipher_key   (ke_cipher_key),
        .ke_cipher_new_en(ke_cipher_new_en),
        .ke_round_key_en (ke_round_key_en),
        .ke_round_num    (ke_round_num),
        .ke_en           (ke_en),
        .ke_round_key    (ke_round_key),
        .replay_req      (replay_req),
        .cache_valid     (cache_valid)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic init_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_tab[a] = s;
        end
    endtask

    // Round key r from round key r-1 (FIPS-197 AES-128 expansion).
    function automatic logic [KW-1:0] next_rk(input logic [KW-1:0] k, input int r);
        logic [7:0]  rc = 8'h01;
        logic [31:0] rot, t, n0, n1, n2, n3;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        rot = {k[23:0], k[31:24]};
        t   = {sbox_tab[rot[31:24]] ^ rc, sbox_tab[rot[23:16]], sbox_tab[rot[15:8]], sbox_tab[rot[7:0]]};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic build_ref(input logic [KW-1:0] k);
        ref_rk[0] = k;
        for (int r = 1; r <= 10; r++) ref_rk[r] = next_rk(ref_rk[r-1], r);
    endtask

    // Expander datapath: load computes round key 1, advance computes round key num+1.
    always @(posedge clk) begin
        if (ke_cipher_new_en)     exp_reg <= next_rk(ke_cipher_key, 1);
        else if (ke_round_key_en) exp_reg <= next_rk(exp_reg, int'(ke_round_num) + 1);
    end
    assign ke_round_key = exp_reg;

    task automatic load_key(input logic [KW-1:0] k);
        @(negedge clk);
        key_valid  = 1'b1;
        cipher_key = k;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        reset = 1'b1; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0;
        replay_req = 1'b0; cipher_key = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({rk_valid, sched_done, cache_valid, ke_cipher_new_en, ke_round_key_en, ke_en, key_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000001", {rk_valid, sched_done, cache_valid,
                     ke_cipher_new_en, ke_round_key_en, ke_en, key_ready});
        end
        checks++;
        if (rk_idx !== 4'd0 || ke_round_num !== 4'd0 || ke_cipher_key !== '0) begin
            failures++;
            $display("FAIL reset_regs: got idx=%0d num=%0d key=%h want 0 0 0", rk_idx, ke_round_num, ke_cipher_key);
        end
    endtask

    task automatic test_fips_full();
        build_ref(FIPS_KEY);
        rk_ready = 1'b1;
        load_key(FIPS_KEY);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_data !== ref_rk[i]) begin
                failures++;
                $display("FAIL fips_key: got v=%b idx=%0d data=%h want v=1 idx=%0d data=%h", rk_valid, rk_idx, rk_data, i, ref_rk[i]);
            end
            checks++;
            if (ke_cipher_new_en !== (i == 0) || ke_round_key_en !== (i >= 1 && i <= 9) || ke_round_num !== 4'(i)) begin
                failures++;
                $display("FAIL fips_strobe: got new=%b adv=%b num=%0d at idx %0d", ke_cipher_new_en, ke_round_key_en, ke_round_num, i);
            end
            if (i == 10) begin
                checks++;
                if (rk_data !== FIPS_RK10) begin
                    failures++;
                    $display("FAIL fips_rk10: got %h want %h", rk_data, FIPS_RK10);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b1 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL fips_done: got done=%b v=%b kr=%b want 1 0 1", sched_done, rk_valid, key_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got %b want 0", sched_done);
        end
    endtask

    task automatic test_stall();
        int exp_i = 0;
        int stalls = 0;
        int budget = 40;
        build_ref(FIPS_KEY);
        load_key(FIPS_KEY);
        while (exp_i <= 10 && budget > 0) begin
            @(negedge clk);
            rk_ready = !(exp_i == 4 && stalls < 3);
            #1;
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(exp_i) || rk_data !== ref_rk[exp_i]) begin
                failures++;
                $display("FAIL stall_key: got idx=%0d data=%h want idx=%0d data=%h", rk_idx, rk_data, exp_i, ref_rk[exp_i]);
            end
            checks++;
            if (ke_cipher_new_en !== (rk_ready && exp_i == 0) || ke_round_key_en !== (rk_ready && exp_i >= 1 && exp_i <= 9)) begin
                failures++;
                $display("FAIL stall_strobe: got new=%b adv=%b ready=%b idx=%0d", ke_cipher_new_en, ke_round_key_en, rk_ready, exp_i);
            end
            if (rk_ready) exp_i++;
            else stalls++;
            budget--;
        end
        checks++;
        if (exp_i != 11) begin
            failures++;
            $display("FAIL stall_timeout: got %0d keys want 11", exp_i);
        end
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done: got %b want 1", sched_done);
        end
    endtask

    task automatic test_backpressure(input int n_keys);
        for (int n = 0; n < n_keys; n++) begin
            logic [KW-1:0] k;
            int exp_i, budget;
            k = {$urandom, $urandom, $urandom, $urandom};
            exp_i = 0;
            budget = 200;
            checks++;
            if (key_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_key_ready: got %b want 1", key_ready);
            end
            build_ref(k);
            load_key(k);
            while (exp_i <= 10 && budget > 0) begin
                @(negedge clk);
                rk_ready = 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (rk_valid !== 1'b1 || rk_idx !== 4'(exp_i) || rk_data !== ref_rk[exp_i]) begin
                    failures++;
                    $display("FAIL bp_key: got idx=%0d data=%h want idx=%0d data=%h", rk_idx, rk_data, exp_i, ref_rk[exp_i]);
                end
                checks++;
                if (ke_cipher_new_en !== (rk_ready && exp_i == 0) || ke_round_key_en !== (rk_ready && exp_i >= 1 && exp_i <= 9)) begin
                    failures++;
                    $display("FAIL bp_strobe: got new=%b adv=%b ready=%b idx=%0d", ke_cipher_new_en, ke_round_key_en, rk_ready, exp_i);
                end
                if (rk_ready) exp_i++;
                budget--;
            end
            checks++;
            if (exp_i != 11) begin
                failures++;
                $display("FAIL bp_timeout: got %0d keys want 11", exp_i);
            end
            @(negedge clk); #1;
            checks++;
            if (sched_done !== 1'b1 || rk_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_done: got done=%b v=%b want 1 0", sched_done, rk_valid);
            end
        end
    endtask

    task automatic test_abort();
        logic [KW-1:0] k1, k2;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        build_ref(k1);
        rk_ready = 1'b1;
        load_key(k1);
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            abort = (i == 6);
            #1;
            checks++;
            if (rk_idx !== 4'(i) || rk_data !== ref_rk[i]) begin
                failures++;
                $display("FAIL abort_pre: got idx=%0d data=%h want idx=%0d data=%h", rk_idx, rk_data, i, ref_rk[i]);
            end
            if (i == 6) begin
                checks++;
                if (ke_cipher_new_en !== 1'b0 || ke_round_key_en !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_strobe: got new=%b adv=%b want 0 0", ke_cipher_new_en, ke_round_key_en);
                end
            end
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || sched_done !== 1'b0 || cache_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got v=%b kr=%b done=%b cv=%b want 0 1 0 0", rk_valid, key_ready, sched_done, cache_valid);
        end
        build_ref(k2);
        load_key(k2);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_data !== ref_rk[i]) begin
                failures++;
                $display("FAIL abort_restart: got idx=%0d data=%h want idx=%0d data=%h", rk_idx, rk_data, i, ref_rk[i]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_done: got %b want 1", sched_done);
        end
    endtask

    task automatic test_key_ignored();
        logic [KW-1:0] k1, k2;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k1;
        build_ref(k1);
        rk_ready = 1'b1;
        load_key(k1);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            key_valid  = (i == 5);
            cipher_key = k2;
            #1;
            checks++;
            if (rk_idx !== 4'(i) || rk_data !== ref_rk[i] || ke_cipher_key !== k1 || key_ready !== 1'b0) begin
                failures++;
                $display("FAIL ignore_key: got idx=%0d data=%h kreg=%h kr=%b want idx=%0d data=%h kreg=%h kr=0",
                         rk_idx, rk_data, ke_cipher_key, key_ready, i, ref_rk[i], k1);
            end
        end
        key_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b1 || rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignore_done: got done=%b v=%b want 1 0", sched_done, rk_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [KW-1:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        rk_ready = 1'b1;
        load_key(k);
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            reset = (i == 3);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({rk_valid, sched_done, cache_valid, ke_cipher_new_en, ke_round_key_en, ke_en, key_ready} !== 7'b0000001
            || rk_idx !== 4'd0 || ke_round_num !== 4'd0 || ke_cipher_key !== '0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b idx=%0d num=%0d key=%h want 0000001 0 0 0",
                     {rk_valid, sched_done, cache_valid, ke_cipher_new_en, ke_round_key_en, ke_en, key_ready},
                     rk_idx, ke_round_num, ke_cipher_key);
        end
    endtask

`ifdef AES_KEY_CACHE_EN
    task automatic test_replay();
        logic [KW-1:0] k, k3;
        int exp_i = 10;
        int budget = 100;
        k  = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        build_ref(k);
        rk_ready = 1'b1;
        load_key(k);
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (cache_valid !== 1'b1) begin
            failures++;
            $display("FAIL cache_valid_set: got %b want 1", cache_valid);
        end
        replay_req = 1'b1;
        @(posedge clk); #1;
        replay_req = 1'b0;
        while (exp_i >= 0 && budget > 0) begin
            @(negedge clk);
            rk_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (rk_valid !== 1'b1 || rk_idx !== 4'(exp_i) || rk_data !== ref_rk[exp_i]) begin
                failures++;
                $display("FAIL replay_key: got idx=%0d data=%h want idx=%0d data=%h", rk_idx, rk_data, exp_i, ref_rk[exp_i]);
            end
            checks++;
            if (ke_cipher_new_en !== 1'b0 || ke_round_key_en !== 1'b0) begin
                failures++;
                $display("FAIL replay_strobe: got new=%b adv=%b want 0 0", ke_cipher_new_en, ke_round_key_en);
            end
            if (rk_ready) exp_i--;
            budget--;
        end
        checks++;
        if (exp_i != -1) begin
            failures++;
            $display("FAIL replay_timeout: stopped at idx %0d want all 11", exp_i);
        end
        rk_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (sched_done !== 1'b1 || rk_valid !== 1'b0 || cache_valid !== 1'b1) begin
            failures++;
            $display("FAIL replay_done: got done=%b v=%b cv=%b want 1 0 1", sched_done, rk_valid, cache_valid);
        end
        @(negedge clk);
        key_valid = 1'b1; replay_req = 1'b1; cipher_key = k3;
        @(posedge clk); #1;
        key_valid = 1'b0; replay_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rk_idx !== 4'd0 || rk_data !== k3 || cache_valid !== 1'b0) begin
            failures++;
            $display("FAIL replay_tie: got idx=%0d data=%h cv=%b want idx=0 data=%h cv=0", rk_idx, rk_data, cache_valid, k3);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL replay_tie_abort: got v=%b kr=%b want 0 1", rk_valid, key_ready);
        end
    endtask
`else
    task automatic test_no_cache();
        checks++;
        if (cache_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_cache_valid: got %b want 0", cache_valid);
        end
        @(negedge clk);
        replay_req = 1'b1;
        @(posedge clk); #1;
        replay_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || cache_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_cache_replay: got v=%b kr=%b cv=%b want 0 1 0", rk_valid, key_ready, cache_valid);
        end
    endtask
`endif

    initial begin
        init_sbox();
        test_reset();
        test_fips_full();
        test_stall();
        test_backpressure(4);
        test_abort();
        test_key_ignored();
`ifdef AES_KEY_CACHE_EN
        test_replay();
`else
        test_no_cache();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
